// File: rtl/locker_code_reg.sv
// Locker entry register: shifts digits in, backspaces, checks/reprograms a key; LOCKOUT_EN adds fail lockout.
// Latency: every output is registered and valid one C edge after the command; Qn is ~Q combinationally.
// Backpressure: none; commands are level-sampled each edge, EN when FULL / BKSP when empty are dropped.
module locker_code_reg #(
    parameter int                           DIGIT_W  = 4,
    parameter int                           DIGITS   = 4,
    parameter logic [DIGIT_W*DIGITS-1:0]    CODE     = 16'h2418,
    parameter int                           MAX_FAIL = 3,
    parameter int                           LOCK_CYC = 16
) (
    input  logic                            C,
    input  logic                            CLR,
    input  logic                            EN,
    input  logic [DIGIT_W-1:0]              D,
    input  logic                            BKSP,
    input  logic                            CHECK,
    input  logic                            SET,
    output logic [DIGIT_W*DIGITS-1:0]       Q,
    output logic [DIGIT_W*DIGITS-1:0]       Qn,
    output logic [$clog2(DIGITS+1)-1:0]     CNT,
    output logic                            FULL,
    output logic                            OK,
    output logic                            FAIL,
    output logic                            LOCKED
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [W-1:0]  q_r;
    logic [W-1:0]  key_r;
    logic [CW-1:0] cnt_r;
    logic          ok_r;
    logic          fail_r;
    logic          full;
    logic          match;
    logic          hold;

    assign full  = (cnt_r == CW'(DIGITS));
    assign match = full && (q_r == key_r);

`ifdef LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCK_CYC + 1);

    logic          locked_r;
    logic [FW-1:0] fail_cnt_r;
    logic [TW-1:0] lock_tmr_r;

    // The timer is loaded on the locking edge, so LOCKED stays high for exactly LOCK_CYC edges.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            locked_r   <= 1'b0;
            fail_cnt_r <= '0;
            lock_tmr_r <= '0;
        end else if (locked_r) begin
            if (lock_tmr_r == TW'(1)) begin
                locked_r   <= 1'b0;
                lock_tmr_r <= '0;
                fail_cnt_r <= '0;
            end else begin
                lock_tmr_r <= lock_tmr_r - TW'(1);
            end
        end else if (CHECK) begin
            if (match) begin
                fail_cnt_r <= '0;
            end else begin
                fail_cnt_r <= fail_cnt_r + FW'(1);
                if (fail_cnt_r == FW'(MAX_FAIL - 1)) begin
                    locked_r   <= 1'b1;
                    lock_tmr_r <= TW'(LOCK_CYC);
                end
            end
        end
    end

    assign hold   = locked_r;
    assign LOCKED = locked_r;
`else
    logic unused_cfg;

    assign unused_cfg = ^{MAX_FAIL[0], LOCK_CYC[0]};
    assign hold       = 1'b0;
    assign LOCKED     = 1'b0;
`endif

    // Priority CHECK > SET > BKSP > EN; exactly one command acts per edge.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            q_r    <= '0;
            key_r  <= CODE;
            cnt_r  <= '0;
            ok_r   <= 1'b0;
            fail_r <= 1'b0;
        end else begin
            ok_r   <= 1'b0;
            fail_r <= 1'b0;
            if (!hold) begin
                if (CHECK) begin
                    ok_r   <= match;
                    fail_r <= !match;
                    q_r    <= '0;
                    cnt_r  <= '0;
                end else if (SET) begin
                    if (full) begin
                        key_r <= q_r;
                        q_r   <= '0;
                        cnt_r <= '0;
                    end
                end else if (BKSP) begin
                    if (cnt_r != '0) begin
                        q_r   <= q_r >> DIGIT_W;
                        cnt_r <= cnt_r - CW'(1);
                    end
                end else if (EN) begin
                    if (!full) begin
                        q_r   <= {q_r[W-DIGIT_W-1:0], D};
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
            end
        end
    end

    assign Q    = q_r;
    assign Qn   = ~q_r;
    assign CNT  = cnt_r;
    assign FULL = full;
    assign OK   = ok_r;
    assign FAIL = fail_r;

endmodule

// File: tb/tb_locker_code_reg.sv
// Testbench for locker_code_reg: directed steps plus random commands against a digit-queue model.
module tb_locker_code_reg;

    localparam int          DIGIT_W  = 4;
    localparam int          DIGITS   = 4;
    localparam logic [15:0] CODE     = 16'h2418;
    localparam int          MAX_FAIL = 3;
    localparam int          LOCK_CYC = 16;
`ifdef LOCKOUT_EN
    localparam bit          LOCK_ON  = 1'b1;
`else
    localparam bit          LOCK_ON  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        en = 1'b0, bksp = 1'b0, check = 1'b0, set = 1'b0;
    logic [3:0]  d = '0;
    logic [15:0] q, qn;
    logic [2:0]  cnt;
    logic        full, ok, fail, locked;

    int ntests = 0;
    int nfail  = 0;

    // Reference model: entered digits oldest-first, plus key and lockout bookkeeping.
    int          digits[$];
    int          key;
    int          fails;
    int          lock_left;
    bit          exp_ok, exp_fail;

    always #5 clk = ~clk;

    locker_code_reg #(
        .DIGIT_W (DIGIT_W),
        .DIGITS  (DIGITS),
        .CODE    (CODE),
        .MAX_FAIL(MAX_FAIL),
        .LOCK_CYC(LOCK_CYC)
    ) dut (
        .C     (clk),
        .CLR   (clr),
        .EN    (en),
        .D     (d),
        .BKSP  (bksp),
        .CHECK (check),
        .SET   (set),
        .Q     (q),
        .Qn    (qn),
        .CNT   (cnt),
        .FULL  (full),
        .OK    (ok),
        .FAIL  (fail),
        .LOCKED(locked)
    );

    function automatic int entry_val();
        int v = 0;
        foreach (digits[i]) v = v * 16 + digits[i];
        return v;
    endfunction

    task automatic model_reset();
        digits.delete();
        key       = int'(CODE);
        fails     = 0;
        lock_left = 0;
        exp_ok    = 1'b0;
        exp_fail  = 1'b0;
    endtask

    task automatic model_step(input bit e, input int dv, input bit b, input bit c, input bit s);
        exp_ok   = 1'b0;
        exp_fail = 1'b0;
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (c) begin
            if (digits.size() == DIGITS && entry_val() == key) begin
                exp_ok = 1'b1;
                fails  = 0;
            end else begin
                exp_fail = 1'b1;
                if (LOCK_ON) begin
                    fails++;
                    if (fails == MAX_FAIL) lock_left = LOCK_CYC;
                end
            end
            digits.delete();
        end else if (s) begin
            if (digits.size() == DIGITS) begin
                key = entry_val();
                digits.delete();
            end
        end else if (b) begin
            if (digits.size() > 0) void'(digits.pop_back());
        end else if (e) begin
            if (digits.size() < DIGITS) digits.push_back(dv);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".Q"},      {16'h0, q},      32'(entry_val()));
        chk({tag, ".Qn"},     {16'h0, qn},     {16'h0, ~16'(entry_val())});
        chk({tag, ".CNT"},    {29'h0, cnt},    32'(digits.size()));
        chk({tag, ".FULL"},   {31'h0, full},   {31'h0, digits.size() == DIGITS});
        chk({tag, ".OK"},     {31'h0, ok},     {31'h0, exp_ok});
        chk({tag, ".FAIL"},   {31'h0, fail},   {31'h0, exp_fail});
        chk({tag, ".LOCKED"}, {31'h0, locked}, {31'h0, lock_left > 0});
    endtask

    task automatic cyc(input string tag, input bit e, input int dv, input bit b, input bit c, input bit s);
        en = e; d = 4'(dv); bksp = b; check = c; set = s;
        @(posedge clk);
        #1;
        en = 1'b0; bksp = 1'b0; check = 1'b0; set = 1'b0;
        model_step(e, dv, b, c, s);
        check_outs(tag);
    endtask

    task automatic enter4(input string tag, input int v);
        for (int i = 3; i >= 0; i--) cyc(tag, 1'b1, (v >> (4 * i)) & 15, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #2;
        check_outs("reset");
        chk("reset.Qn_ones", {16'h0, qn}, 32'h0000_FFFF);
        #6;
        clr = 1'b0;
        #3;

        enter4("entry", 32'h2418);
        chk("entry.Q_const", {16'h0, q}, 32'h2418);
        chk("entry.Qn_const", {16'h0, qn}, 32'hDBE7);
        cyc("en_full", 1'b1, 5, 1'b0, 1'b0, 1'b0);
        chk("en_full.Q_const", {16'h0, q}, 32'h2418);

        cyc("bksp", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("bksp.Q_const", {16'h0, q}, 32'h0241);
        cyc("en9", 1'b1, 9, 1'b0, 1'b0, 1'b0);
        chk("en9.Q_const", {16'h0, q}, 32'h2419);
        cyc("chk_wrong", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("chk_wrong.FAIL_const", {31'h0, fail}, 32'h1);
        cyc("after_wrong", 1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc("bksp_empty", 1'b0, 0, 1'b1, 1'b0, 1'b0);

        enter4("entry_ok", 32'h2418);
        cyc("chk_ok", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("chk_ok.OK_const", {31'h0, ok}, 32'h1);
        cyc("after_ok", 1'b0, 0, 1'b0, 1'b0, 1'b0);

        enter4("newkey", 32'h1234);
        cyc("set", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        enter4("entry_new", 32'h1234);
        cyc("chk_new", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("chk_new.OK_const", {31'h0, ok}, 32'h1);
        cyc("part1", 1'b1, 1, 1'b0, 1'b0, 1'b0);
        cyc("part2", 1'b1, 2, 1'b0, 1'b0, 1'b0);
        cyc("set_partial", 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("set_partial.CNT_const", {29'h0, cnt}, 32'h2);
        cyc("chk_partial", 1'b0, 0, 1'b0, 1'b1, 1'b0);

        enter4("prio_fill", 32'h1234);
        cyc("prio", 1'b1, 7, 1'b1, 1'b1, 1'b0);
        cyc("prio_set", 1'b0, 0, 1'b1, 1'b0, 1'b1);

        cyc("mid1", 1'b1, 3, 1'b0, 1'b0, 1'b0);
        cyc("mid2", 1'b1, 6, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        #2;
        model_reset();
        check_outs("async_clr");
        #10;
        clr = 1'b0;
        enter4("key_restored", 32'h2418);
        cyc("chk_restored", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("chk_restored.OK_const", {31'h0, ok}, 32'h1);

        enter4("pend", 32'h2418);
        cyc("pend_chk", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        clr = 1'b1;
        #1;
        model_reset();
        check_outs("pend_cancel");
        #8;
        clr = 1'b0;

        if (LOCK_ON) begin
            for (int i = 0; i < MAX_FAIL; i++) cyc("lock_fail", 1'b0, 0, 1'b0, 1'b1, 1'b0);
            chk("lock_on.LOCKED_const", {31'h0, locked}, 32'h1);
            for (int i = 0; i < LOCK_CYC; i++) cyc("lock_en", 1'b1, 2, 1'b0, 1'b0, 1'b0);
            chk("lock_off.LOCKED_const", {31'h0, locked}, 32'h0);
            enter4("unlock", 32'h2418);
            cyc("unlock_chk", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 5) begin
                enter4("rnd_key", key);
            end else begin
                cyc("rnd",
                    $urandom_range(0, 99) < 55,
                    int'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 8,
                    $urandom_range(0, 99) < 8);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
